afc_sar_fsm: RTL and testbench
==============================

AFC_SAR_FSM -- requirements
Module: afc_sar_fsm

Interface
REQ-001 Parameter BAND_W, default 5, band-select code width (legal 2..8).
REQ-002 Parameter SETTLE_CYC, default 4, VCO settle wait in clk cycles before each comparison (legal 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a new calibration.
REQ-006 comp_in  input  3  comparison result, one-hot: FAST=100, SLOW=010, FREEZE=001.
REQ-007 comp_valid  input  1  comp_in is valid this cycle.
REQ-008 comp_req  output  1  level, high while waiting for a comparison result.
REQ-009 band  output  BAND_W  current band-select code driven to the VCO.
REQ-010 band_change  output  1  one-cycle pulse on the cycle after band takes a new value.
REQ-011 busy  output  1  high from search start until lock.
REQ-012 locked  output  1  high once the search has terminated.
REQ-013 cmp_err  output  1  one-cycle pulse when comp_valid arrives with a non-one-hot comp_in.

Function
REQ-014 The block SHALL implement states IDLE, SETTLE, REQ, and LOCK, plus TRACK when configured (REQ-027).
REQ-015 IDLE SHALL hold band = 2^(BAND_W-1) (mid code), busy=0, locked=0, comp_req=0.
REQ-016 start in IDLE or LOCK SHALL load band = mid code and bit pointer = BAND_W-1, clear locked, set busy, and enter SETTLE; start in SETTLE/REQ is ignored.
REQ-017 SETTLE SHALL count SETTLE_CYC cycles and then enter REQ, so comp_req rises exactly SETTLE_CYC+1 edges after the edge sampling start (or the edge of a band update).
REQ-018 In REQ with comp_valid=1: SLOW SHALL keep band[ptr]=1; FAST SHALL clear band[ptr]; if ptr>0, set band[ptr-1]=1, decrement ptr, and re-enter SETTLE.
REQ-019 In REQ, if the decision was made at ptr=0, the block SHALL enter LOCK with the resolved band; a full search therefore takes exactly BAND_W comparisons.
REQ-020 FREEZE in REQ SHALL enter LOCK immediately with band unchanged.
REQ-021 A non-one-hot comp_in with comp_valid in REQ SHALL pulse cmp_err, leave band and ptr unchanged, and re-enter SETTLE.
REQ-022 comp_valid outside REQ SHALL be ignored, with no state or output change.
REQ-023 band_change SHALL pulse only when the band register value actually changes, including on a restart from LOCK to the mid code.
REQ-024 LOCK SHALL hold band, assert locked=1, busy=0, comp_req=0 until start or rst.
REQ-025 Reaching 0 (all FAST) and 2^BAND_W-1 (all SLOW) SHALL both be possible; band never wraps.

Reset
REQ-026 rst=1 at any rising edge, including mid-search, SHALL force IDLE, band = mid code, ptr = BAND_W-1, settle counter = 0, and comp_req, band_change, busy, locked, cmp_err = 0, with no band_change pulse.

Configuration
REQ-027 Macro AFC_TRACK_EN: when defined, LOCK reached via search completion or FREEZE SHALL proceed to TRACK, which loops SETTLE_CYC wait then comp_req.
REQ-028 In TRACK, SLOW SHALL increment band by 1 saturating at 2^BAND_W-1, FAST SHALL decrement by 1 saturating at 0, and FREEZE SHALL hold band; locked stays 1, busy stays 0, and start restarts the search.
REQ-029 Without AFC_TRACK_EN, LOCK SHALL be terminal (REQ-024), and TRACK logic SHALL be absent.

Verification (BAND_W=5, SETTLE_CYC=4)
REQ-030 start, then 5x SLOW -> band 16,24,28,30,31; locked=1; 4 band_change pulses after start (16 unchanged from mid).
REQ-031 start, then 5x FAST -> band 16,8,4,2,1,0; locked=1 with band=0.
REQ-032 start, then FAST, SLOW, FREEZE -> band 16->8->12, lock at 12 after 3 comparisons; comp_req rises 5 cycles after start.
REQ-033 comp_in=110 with comp_valid in REQ -> cmp_err pulse, band unchanged, comp_req re-asserts 5 cycles later.
REQ-034 rst asserted during second SETTLE -> next edge band=16, busy=0, comp_req=0, no band_change.
REQ-035 AFC_TRACK_EN defined, lock at 31, then SLOW -> band stays 31 (saturation); then FAST -> 30 with band_change pulse.

Source files
------------

// File: rtl/afc_sar_fsm_if.sv
// Handshake and band bus between the AFC successive-approximation controller and its VCO/comparator side.
// The slave modport is the controller; the master modport is the driver of start and comparison results.
interface afc_sar_fsm_if #(
    parameter int BAND_W = 5
);
    logic              start;
    logic [2:0]        comp_in;
    logic              comp_valid;
    logic              comp_req;
    logic [BAND_W-1:0] band;
    logic              band_change;
    logic              busy;
    logic              locked;
    logic              cmp_err;

    modport master (
        output start, comp_in, comp_valid,
        input  comp_req, band, band_change, busy, locked, cmp_err
    );

    modport slave (
        input  start, comp_in, comp_valid,
        output comp_req, band, band_change, busy, locked, cmp_err
    );
endinterface

// File: rtl/afc_sar_fsm.sv
// Binary-search (SAR) band calibration for a VCO: settle, request a FAST/SLOW/FREEZE verdict, refine one bit per step.
// Optional macro AFC_TRACK_EN adds a post-lock tracking loop that nudges band by +/-1 per comparison.
module afc_sar_fsm #(
    parameter int BAND_W     = 5,
    parameter int SETTLE_CYC = 4
) (
    input logic         clk,
    input logic         rst,
    afc_sar_fsm_if.slave bus
);
    localparam int                PTR_W       = (BAND_W > 1) ? $clog2(BAND_W) : 1;
    localparam logic [BAND_W-1:0] MID         = {1'b1, {(BAND_W-1){1'b0}}};
    localparam logic [PTR_W-1:0]  PTR_TOP     = PTR_W'(BAND_W - 1);
    localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYC);
    localparam logic [2:0]        C_FAST      = 3'b100;
    localparam logic [2:0]        C_SLOW      = 3'b010;
    localparam logic [2:0]        C_FREEZE    = 3'b001;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        REQ,
        LOCK
`ifdef AFC_TRACK_EN
        , TRACK_SETTLE
        , TRACK_REQ
`endif
    } state_t;

    state_t            state, state_n;
    logic [BAND_W-1:0] band, band_n;
    logic [PTR_W-1:0]  ptr, ptr_n;
    logic [PTR_W-1:0]  ptr_dec;
    logic [7:0]        cnt, cnt_n;
    logic              band_change;
    logic              cmp_err, cmp_err_n;
    logic              restart;
    logic              is_fast, is_slow, is_freeze, one_hot;

    assign is_fast   = (bus.comp_in == C_FAST);
    assign is_slow   = (bus.comp_in == C_SLOW);
    assign is_freeze = (bus.comp_in == C_FREEZE);
    assign one_hot   = is_fast | is_slow | is_freeze;
    assign ptr_dec   = ptr - 1'b1;
    // start is honoured everywhere except mid-search
    assign restart   = bus.start && (state != SETTLE) && (state != REQ);

`ifdef AFC_TRACK_EN
    logic [BAND_W-1:0] band_up, band_dn;
    assign band_up = (band == '1) ? band : band + 1'b1;
    assign band_dn = (band == '0) ? band : band - 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            band        <= MID;
            ptr         <= PTR_TOP;
            cnt         <= '0;
            band_change <= 1'b0;
            cmp_err     <= 1'b0;
        end else begin
            state       <= state_n;
            band        <= band_n;
            ptr         <= ptr_n;
            cnt         <= cnt_n;
            band_change <= (band_n != band);
            cmp_err     <= cmp_err_n;
        end
    end

    always_comb begin
        state_n   = state;
        band_n    = band;
        ptr_n     = ptr;
        cnt_n     = cnt;
        cmp_err_n = 1'b0;
        if (restart) begin
            state_n = SETTLE;
            band_n  = MID;
            ptr_n   = PTR_TOP;
            cnt_n   = '0;
        end else begin
            case (state)
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state_n = REQ;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                REQ: begin
                    if (bus.comp_valid) begin
                        if (!one_hot) begin
                            cmp_err_n = 1'b1;
                            state_n   = SETTLE;
                            cnt_n     = '0;
                        end else if (is_freeze) begin
                            state_n = LOCK;
                        end else begin
                            if (is_fast) band_n[ptr] = 1'b0;
                            if (ptr != '0) begin
                                band_n[ptr_dec] = 1'b1;
                                ptr_n           = ptr_dec;
                                state_n         = SETTLE;
                                cnt_n           = '0;
                            end else begin
                                state_n = LOCK;
                            end
                        end
                    end
                end
`ifdef AFC_TRACK_EN
                LOCK: begin
                    state_n = TRACK_SETTLE;
                    cnt_n   = '0;
                end
                TRACK_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state_n = TRACK_REQ;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                TRACK_REQ: begin
                    if (bus.comp_valid) begin
                        if (!one_hot) cmp_err_n = 1'b1;
                        else if (is_slow) band_n = band_up;
                        else if (is_fast) band_n = band_dn;
                        state_n = TRACK_SETTLE;
                        cnt_n   = '0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy = (state == SETTLE) || (state == REQ);
`ifdef AFC_TRACK_EN
        bus.comp_req = (state == REQ) || (state == TRACK_REQ);
        bus.locked   = (state == LOCK) || (state == TRACK_SETTLE) || (state == TRACK_REQ);
`else
        bus.comp_req = (state == REQ);
        bus.locked   = (state == LOCK);
`endif
    end

    assign bus.band        = band;
    assign bus.band_change = band_change;
    assign bus.cmp_err     = cmp_err;
endmodule

// File: tb/tb_afc_sar_fsm.sv
// Self-checking bench for afc_sar_fsm: directed vector table, hand-written corner sequences,
// and randomized searches checked against an arithmetic SAR model.
module tb_afc_sar_fsm;
    localparam int BAND_W     = 5;
    localparam int SETTLE_CYC = 4;
    localparam int MID        = 1 << (BAND_W - 1);
    localparam int WAIT_MAX   = 50;
    localparam logic [2:0] FAST   = 3'b100;
    localparam logic [2:0] SLOW   = 3'b010;
    localparam logic [2:0] FREEZE = 3'b001;

    typedef struct {
        string seq;
        int    exp_band;
        int    exp_changes;
        int    exp_errs;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   change_cnt = 0;
    int   err_cnt = 0;
    int   base_chg, base_err;
    logic [2:0] stim_q[$];

    always #5 clk = ~clk;

    afc_sar_fsm_if #(.BAND_W(BAND_W)) bus ();

    afc_sar_fsm #(.BAND_W(BAND_W), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(negedge clk) begin
        if (bus.band_change === 1'b1) change_cnt++;
        if (bus.cmp_err === 1'b1) err_cnt++;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [2:0] charToComp(input byte c);
        case (c)
            "S":     return SLOW;
            "F":     return FAST;
            "Z":     return FREEZE;
            default: return 3'b110;
        endcase
    endfunction

    // Expected result of a search: band is a running sum of power-of-two steps.
    function automatic void sarModel(input logic [2:0] q[$], input int start_band,
                                     output int fin, output int changes, output int errs);
        int v = MID;
        int p = BAND_W - 1;
        int prev;
        changes = (start_band != MID) ? 1 : 0;
        errs = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i] == FREEZE) break;
            if (q[i] != SLOW && q[i] != FAST) begin
                errs++;
                continue;
            end
            prev = v;
            if (q[i] == FAST) v -= (1 << p);
            if (p > 0) v += (1 << (p - 1));
            if (v != prev) changes++;
            p--;
        end
        fin = v;
    endfunction

    task automatic waitCompReq(input bit noisy, output int cycles);
        cycles = 0;
        while (bus.comp_req !== 1'b1 && cycles < WAIT_MAX) begin
            if (noisy && $urandom_range(0, 3) == 0) begin
                bus.comp_valid = 1'b1;
                bus.comp_in    = 3'($urandom);
            end
            if (noisy && $urandom_range(0, 5) == 0) bus.start = 1'b1;
            @(posedge clk); #1;
            cycles++;
            bus.comp_valid = 1'b0;
            bus.start      = 1'b0;
        end
    endtask

    task automatic applyStimulus(input bit do_reset, input bit noisy);
        int cycles;
        if (do_reset) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            checkOutput("reset_band", int'(bus.band), MID);
            checkOutput("reset_busy", int'(bus.busy), 0);
            checkOutput("reset_locked", int'(bus.locked), 0);
            checkOutput("reset_comp_req", int'(bus.comp_req), 0);
            checkOutput("reset_band_change", int'(bus.band_change), 0);
        end
        base_chg = change_cnt;
        base_err = err_cnt;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checkOutput("busy_after_start", int'(bus.busy), 1);
        checkOutput("band_after_start", int'(bus.band), MID);
        for (int i = 0; i < stim_q.size(); i++) begin
            waitCompReq(noisy, cycles);
            checkOutput("comp_req_latency", cycles, SETTLE_CYC + 1);
            bus.comp_in    = stim_q[i];
            bus.comp_valid = 1'b1;
            @(posedge clk); #1;
            bus.comp_valid = 1'b0;
        end
        @(negedge clk); #1;
    endtask

    task automatic checkLock(input string tag, input int exp_band, input int exp_chg, input int exp_err);
        checkOutput({tag, "_band"}, int'(bus.band), exp_band);
        checkOutput({tag, "_locked"}, int'(bus.locked), 1);
        checkOutput({tag, "_busy"}, int'(bus.busy), 0);
        checkOutput({tag, "_comp_req"}, int'(bus.comp_req), 0);
        checkOutput({tag, "_changes"}, change_cnt - base_chg, exp_chg);
        checkOutput({tag, "_errs"}, err_cnt - base_err, exp_err);
    endtask

    vec_t vecs[5];

    initial begin
        int cycles, fin, chg, errs, prev_band, nvalid, r;
        logic [2:0] bad[5];

        vecs[0] = '{seq: "SSSSS",  exp_band: 31, exp_changes: 4, exp_errs: 0};
        vecs[1] = '{seq: "FSZ",    exp_band: 12, exp_changes: 2, exp_errs: 0};
        vecs[2] = '{seq: "SXFSSF", exp_band: 22, exp_changes: 5, exp_errs: 1};
        vecs[3] = '{seq: "FSFSS",  exp_band: 11, exp_changes: 4, exp_errs: 0};
        vecs[4] = '{seq: "FFFFF",  exp_band: 0,  exp_changes: 5, exp_errs: 0};
        bad = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.comp_in = 3'b000;
        bus.comp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            stim_q.delete();
            for (int i = 0; i < vecs[v].seq.len(); i++) stim_q.push_back(charToComp(vecs[v].seq[i]));
            applyStimulus(1'b1, 1'b0);
            checkLock($sformatf("vec%0d", v), vecs[v].exp_band, vecs[v].exp_changes, vecs[v].exp_errs);
        end

        // Restart from a lock at band 0 must reload mid code with a band_change pulse.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checkOutput("restart_band", int'(bus.band), MID);
        checkOutput("restart_locked", int'(bus.locked), 0);
        checkOutput("restart_busy", int'(bus.busy), 1);
        @(negedge clk);
        checkOutput("restart_band_change", int'(bus.band_change), 1);

        // Reset in the second settle window.
        @(posedge clk); #1;
        waitCompReq(1'b0, cycles);
        checkOutput("midrst_latency", cycles, SETTLE_CYC);
        bus.comp_in = SLOW;
        bus.comp_valid = 1'b1;
        @(posedge clk); #1;
        bus.comp_valid = 1'b0;
        checkOutput("midrst_band_before", int'(bus.band), 24);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midrst_band", int'(bus.band), MID);
        checkOutput("midrst_busy", int'(bus.busy), 0);
        checkOutput("midrst_comp_req", int'(bus.comp_req), 0);
        checkOutput("midrst_band_change", int'(bus.band_change), 0);
        checkOutput("midrst_locked", int'(bus.locked), 0);

        stim_q.delete();
        repeat (BAND_W) stim_q.push_back(SLOW);
        applyStimulus(1'b1, 1'b0);
        checkLock("pretrack", 31, 4, 0);
`ifdef AFC_TRACK_EN
        waitCompReq(1'b0, cycles);
        checkOutput("track_req_seen", int'(bus.comp_req), 1);
        bus.comp_in = SLOW;
        bus.comp_valid = 1'b1;
        @(posedge clk); #1;
        bus.comp_valid = 1'b0;
        checkOutput("track_sat_band", int'(bus.band), 31);
        @(negedge clk);
        checkOutput("track_sat_change", int'(bus.band_change), 0);
        waitCompReq(1'b0, cycles);
        bus.comp_in = FAST;
        bus.comp_valid = 1'b1;
        @(posedge clk); #1;
        bus.comp_valid = 1'b0;
        checkOutput("track_dec_band", int'(bus.band), 30);
        checkOutput("track_locked", int'(bus.locked), 1);
        checkOutput("track_busy", int'(bus.busy), 0);
        @(negedge clk);
        checkOutput("track_dec_change", int'(bus.band_change), 1);
        #1;
`else
        repeat (20) @(posedge clk);
        #1;
        checkOutput("lock_hold_comp_req", int'(bus.comp_req), 0);
        checkOutput("lock_hold_locked", int'(bus.locked), 1);
        checkOutput("lock_hold_band", int'(bus.band), 31);
`endif

        prev_band = int'(bus.band);
        for (int n = 0; n < 25; n++) begin
            stim_q.delete();
            nvalid = 0;
            while (nvalid < BAND_W) begin
                r = $urandom_range(0, 19);
                if (r < 1) begin
                    stim_q.push_back(FREEZE);
                    break;
                end else if (r < 3) begin
                    stim_q.push_back(bad[$urandom_range(0, 4)]);
                end else begin
                    stim_q.push_back((r % 2 == 0) ? SLOW : FAST);
                    nvalid++;
                end
            end
            if (n == 0) prev_band = MID;
            sarModel(stim_q, prev_band, fin, chg, errs);
            applyStimulus(n == 0, 1'b1);
            checkLock($sformatf("rand%0d", n), fin, chg, errs);
            prev_band = fin;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
